// File: rtl/pepper_manager_if.sv
// Signal bundle between the pepper controller and its surroundings (keyboard, motion, enemy AI).
// The master side drives the inputs; the controller sits on the slave side.
interface pepper_manager_if #(
    parameter int N_ENEMY    = 4,
    parameter int PEPPER_MAX = 5
);
    localparam int PC_W = $clog2(PEPPER_MAX + 1);

    logic [7:0]            keycode;
    logic [9:0]            ChefX;
    logic [9:0]            ChefY;
    logic                  chef_left;
    logic [10*N_ENEMY-1:0] EnemyX;
    logic [10*N_ENEMY-1:0] EnemyY;
    logic [N_ENEMY-1:0]    enemy_alive;
    logic                  refill;
    logic [PC_W-1:0]       pepper_count;
    logic                  have_pepper;
    logic                  spray_active;
    logic                  throw_pulse;
    logic [N_ENEMY-1:0]    enemy_stunned;
    logic [N_ENEMY-1:0]    enemy_flash;

    modport master (
        output keycode, ChefX, ChefY, chef_left, EnemyX, EnemyY, enemy_alive, refill,
        input  pepper_count, have_pepper, spray_active, throw_pulse, enemy_stunned, enemy_flash
    );

    modport slave (
        input  keycode, ChefX, ChefY, chef_left, EnemyX, EnemyY, enemy_alive, refill,
        output pepper_count, have_pepper, spray_active, throw_pulse, enemy_stunned, enemy_flash
    );
endinterface

// File: rtl/pepper_manager.sv
// Chef pepper-spray controller: pepper supply, one spray per key press, per-enemy stun timers.
// Define PEPPER_STUN_FLASH_EN to blink enemy_flash during the last quarter of a stun.
module pepper_manager #(
    parameter int N_ENEMY      = 4,
    parameter int PEPPER_INIT  = 3,
    parameter int PEPPER_MAX   = 5,
    parameter int STUN_FRAMES  = 600,
    parameter int SPRAY_FRAMES = 8,
    parameter int HIT_DX       = 24,
    parameter int HIT_DY       = 4,
    parameter int KEY_PEPPER   = 19,
    parameter int CNT_W        = 10
) (
    input  logic             frame_clk,
    input  logic             Reset,
    pepper_manager_if.slave  bus
);
    localparam int PC_W  = $clog2(PEPPER_MAX + 1);
    localparam int TMR_W = $clog2(SPRAY_FRAMES + 1);

    localparam logic [PC_W-1:0]  CNT_INIT   = PC_W'(PEPPER_INIT);
    localparam logic [PC_W-1:0]  CNT_MAX    = PC_W'(PEPPER_MAX);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(SPRAY_FRAMES);
    localparam logic [CNT_W-1:0] STUN_LOAD  = CNT_W'(STUN_FRAMES);
    localparam logic [10:0]      DX         = 11'(HIT_DX);
    localparam logic [10:0]      DY         = 11'(HIT_DY);
    localparam logic [7:0]       KEY_CODE   = 8'(KEY_PEPPER);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SPRAY    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   spray_tmr_q, spray_tmr_d;
    logic [PC_W-1:0]    count_q, count_d;
    logic               key_prev_q, key_prev_d;
    logic [CNT_W-1:0]   stun_cnt_q [N_ENEMY];
    logic [CNT_W-1:0]   stun_cnt_d [N_ENEMY];
    logic               have_pepper_q, have_pepper_d;
    logic               spray_active_q, spray_active_d;
    logic               throw_pulse_q, throw_pulse_d;
    logic [N_ENEMY-1:0] stunned_q, stunned_d;
    logic [N_ENEMY-1:0] flash_q, flash_d;

    logic               key_now;
    logic               accept;
    logic [N_ENEMY-1:0] hit;

    // Box test in 11 bits so chef+reach never wraps; lower bounds clamp at 0.
    function automatic logic hit_test(input logic [9:0] cx, input logic [9:0] cy,
                                      input logic [9:0] ex, input logic [9:0] ey,
                                      input logic left);
        logic [10:0] x_c, y_c, x_e, y_e, x_lo, x_hi, y_lo, y_hi;
        x_c = {1'b0, cx};
        y_c = {1'b0, cy};
        x_e = {1'b0, ex};
        y_e = {1'b0, ey};
        if (left) begin
            x_lo = (x_c >= DX) ? (x_c - DX) : 11'd0;
            x_hi = x_c;
        end else begin
            x_lo = x_c;
            x_hi = x_c + DX;
        end
        y_lo = (y_c >= DY) ? (y_c - DY) : 11'd0;
        y_hi = y_c + DY;
        return (x_e >= x_lo) && (x_e <= x_hi) && (y_e >= y_lo) && (y_e <= y_hi);
    endfunction

`ifdef PEPPER_STUN_FLASH_EN
    localparam logic [CNT_W-1:0] FLASH_BELOW = CNT_W'(STUN_FRAMES / 4);

    function automatic logic flash_of(input logic [CNT_W-1:0] c);
        return (c != {CNT_W{1'b0}}) && (c < FLASH_BELOW) && c[3];
    endfunction
`endif

    // Throw acceptance and spray FSM next state.
    always_comb begin
        state_d     = state_q;
        spray_tmr_d = spray_tmr_q;
        key_now     = (bus.keycode == KEY_CODE);
        key_prev_d  = key_now;
        accept      = key_now && !key_prev_q && (state_q == ST_IDLE) &&
                      (count_q != {PC_W{1'b0}});
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_SPRAY;
                    spray_tmr_d = TMR_LOAD;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_SPRAY: begin
                spray_tmr_d = spray_tmr_q - TMR_W'(1);
                if (spray_tmr_q == TMR_W'(1)) begin
                    state_d = key_now ? ST_COOLDOWN : ST_IDLE;
                end else begin
                    state_d = ST_SPRAY;
                end
            end
            ST_COOLDOWN: begin
                if (!key_now) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COOLDOWN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                spray_tmr_d = {TMR_W{1'b0}};
            end
        endcase
    end

    // Pepper supply: a throw and a refill on the same edge cancel out.
    always_comb begin
        count_d = count_q;
        if (accept && !bus.refill) begin
            count_d = count_q - PC_W'(1);
        end else if (!accept && bus.refill && (count_q < CNT_MAX)) begin
            count_d = count_q + PC_W'(1);
        end else begin
            count_d = count_q;
        end
        have_pepper_d  = (count_d != {PC_W{1'b0}});
        spray_active_d = (state_d == ST_SPRAY);
        throw_pulse_d  = accept;
    end

    // Per-enemy hit test and stun countdown (death beats hit beats decay).
    always_comb begin
        hit       = {N_ENEMY{1'b0}};
        stunned_d = {N_ENEMY{1'b0}};
        flash_d   = {N_ENEMY{1'b0}};
        for (int i = 0; i < N_ENEMY; i++) begin
            stun_cnt_d[i] = stun_cnt_q[i];
            hit[i] = (state_q == ST_SPRAY) && bus.enemy_alive[i] &&
                     hit_test(bus.ChefX, bus.ChefY, bus.EnemyX[10*i +: 10],
                              bus.EnemyY[10*i +: 10], bus.chef_left);
            if (!bus.enemy_alive[i]) begin
                stun_cnt_d[i] = {CNT_W{1'b0}};
            end else if (hit[i]) begin
                stun_cnt_d[i] = STUN_LOAD;
            end else if (stun_cnt_q[i] != {CNT_W{1'b0}}) begin
                stun_cnt_d[i] = stun_cnt_q[i] - CNT_W'(1);
            end else begin
                stun_cnt_d[i] = stun_cnt_q[i];
            end
            stunned_d[i] = (stun_cnt_d[i] != {CNT_W{1'b0}});
`ifdef PEPPER_STUN_FLASH_EN
            flash_d[i] = flash_of(stun_cnt_d[i]);
`else
            flash_d[i] = 1'b0;
`endif
        end
    end

    // State and output registers; reset aborts any spray or stun in progress.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            spray_tmr_q    <= {TMR_W{1'b0}};
            count_q        <= CNT_INIT;
            key_prev_q     <= 1'b0;
            have_pepper_q  <= (CNT_INIT != {PC_W{1'b0}});
            spray_active_q <= 1'b0;
            throw_pulse_q  <= 1'b0;
            stunned_q      <= {N_ENEMY{1'b0}};
            flash_q        <= {N_ENEMY{1'b0}};
            for (int i = 0; i < N_ENEMY; i++) begin
                stun_cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q        <= state_d;
            spray_tmr_q    <= spray_tmr_d;
            count_q        <= count_d;
            key_prev_q     <= key_prev_d;
            have_pepper_q  <= have_pepper_d;
            spray_active_q <= spray_active_d;
            throw_pulse_q  <= throw_pulse_d;
            stunned_q      <= stunned_d;
            flash_q        <= flash_d;
            for (int i = 0; i < N_ENEMY; i++) begin
                stun_cnt_q[i] <= stun_cnt_d[i];
            end
        end
    end

    assign bus.pepper_count  = count_q;
    assign bus.have_pepper   = have_pepper_q;
    assign bus.spray_active  = spray_active_q;
    assign bus.throw_pulse   = throw_pulse_q;
    assign bus.enemy_stunned = stunned_q;
    assign bus.enemy_flash   = flash_q;
endmodule

// File: tb/tb_pepper_manager.sv
// Bench for pepper_manager: a frame-level reference model pushes expected outputs per edge,
// which are popped and compared after the edge, plus directed checks of the key scenarios.
module tb_pepper_manager;
    logic clk;
    logic Reset;

    pepper_manager_if #(.N_ENEMY(4), .PEPPER_MAX(5)) bus ();

    pepper_manager dut (
        .frame_clk (clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] cnt;
        logic       have;
        logic       spray;
        logic       thr;
        logic [3:0] stn;
        logic [3:0] fl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // model state
    int   m_count;
    int   m_state;     // 0 idle, 1 spray, 2 cooldown
    int   m_tmr;
    bit   m_keyprev;
    int   m_stun [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_enemy(input int i, input int x, input int y);
        bus.EnemyX[10*i +: 10] = 10'(x);
        bus.EnemyY[10*i +: 10] = 10'(y);
    endtask

    task automatic model_reset();
        m_count   = 3;
        m_state   = 0;
        m_tmr     = 0;
        m_keyprev = 1'b0;
        for (int i = 0; i < 4; i++) m_stun[i] = 0;
        q.delete();
    endtask

    // One frame: predict, push, clock, pop, compare.
    task automatic step();
        exp_t e;
        bit   key_now, press, acc, in_box;
        int   cx, cy, ex, ey;
        key_now = (bus.keycode == 8'd19);
        press   = key_now && !m_keyprev;
        acc     = press && (m_state == 0) && (m_count > 0);
        cx = int'(bus.ChefX);
        cy = int'(bus.ChefY);
        e  = '0;
        for (int i = 0; i < 4; i++) begin
            ex = int'(bus.EnemyX[10*i +: 10]);
            ey = int'(bus.EnemyY[10*i +: 10]);
            if (bus.chef_left) in_box = (ex >= cx - 24) && (ex <= cx);
            else               in_box = (ex >= cx) && (ex <= cx + 24);
            in_box = in_box && (ey - cy <= 4) && (cy - ey <= 4);
            if (!bus.enemy_alive[i])              m_stun[i] = 0;
            else if (m_state == 1 && in_box)      m_stun[i] = 600;
            else if (m_stun[i] > 0)               m_stun[i] = m_stun[i] - 1;
            e.stn[i] = (m_stun[i] != 0);
`ifdef PEPPER_STUN_FLASH_EN
            e.fl[i] = (m_stun[i] != 0) && (m_stun[i] < 150) && (((m_stun[i] >> 3) & 1) == 1);
`else
            e.fl[i] = 1'b0;
`endif
        end
        if (acc && !bus.refill)                      m_count = m_count - 1;
        else if (!acc && bus.refill && m_count < 5)  m_count = m_count + 1;
        case (m_state)
            0: if (acc) begin m_state = 1; m_tmr = 8; end
            1: begin
                if (m_tmr == 1) m_state = key_now ? 2 : 0;
                m_tmr = m_tmr - 1;
            end
            default: if (!key_now) m_state = 0;
        endcase
        m_keyprev = key_now;
        e.cnt   = 3'(m_count);
        e.have  = (m_count != 0);
        e.spray = (m_state == 1);
        e.thr   = acc;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check_eq("sb_count",   bus.pepper_count,  e.cnt);
        check_eq("sb_have",    bus.have_pepper,   e.have);
        check_eq("sb_spray",   bus.spray_active,  e.spray);
        check_eq("sb_throw",   bus.throw_pulse,   e.thr);
        check_eq("sb_stunned", bus.enemy_stunned, e.stn);
        check_eq("sb_flash",   bus.enemy_flash,   e.fl);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #2;
        check_eq("rst_count",   bus.pepper_count,  3);
        check_eq("rst_have",    bus.have_pepper,   1);
        check_eq("rst_spray",   bus.spray_active,  0);
        check_eq("rst_throw",   bus.throw_pulse,   0);
        check_eq("rst_stunned", bus.enemy_stunned, 0);
        check_eq("rst_flash",   bus.enemy_flash,   0);
        model_reset();
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic press_once();
        bus.keycode = 8'd19;
        step();
        bus.keycode = 8'd0;
    endtask

    task automatic setup_right_scene();
        bus.ChefX = 10'd100;
        bus.ChefY = 10'd200;
        bus.chef_left = 1'b0;
        set_enemy(0, 120, 202);
        set_enemy(1, 80, 200);
        set_enemy(2, 500, 500);
        set_enemy(3, 700, 500);
        bus.enemy_alive = 4'b1111;
    endtask

    initial begin
        int n, pulses, sprays, found;
        Reset = 1'b1;
        bus.keycode = 8'd0;
        bus.refill  = 1'b0;
        setup_right_scene();
        model_reset();

        // 1: reset values
        do_reset();

        // 2: single throw, E0 hit, E1 behind chef
        press_once();
        check_eq("t2_pulse", bus.throw_pulse, 1);
        check_eq("t2_count", bus.pepper_count, 2);
        step();
        check_eq("t2_pulse_gone", bus.throw_pulse, 0);
        check_eq("t2_stunned", bus.enemy_stunned, 4'b0001);
        n = 1;
        for (int i = 0; i < 700; i++) begin
            step();
            if (bus.enemy_stunned[0]) n++;
            else break;
        end
        check_eq("t2_stun_len", n, 607);
        check_eq("t2_stun_end", bus.enemy_stunned, 0);

        // 3: hold key 50 frames -> single throw, 8 spray frames; re-press throws again
        do_reset();
        bus.keycode = 8'd19;
        pulses = 0;
        sprays = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            pulses += int'(bus.throw_pulse);
            sprays += int'(bus.spray_active);
        end
        check_eq("t3_pulses", pulses, 1);
        check_eq("t3_spray_len", sprays, 8);
        check_eq("t3_count", bus.pepper_count, 2);
        bus.keycode = 8'd0;
        step();
        step();
        press_once();
        check_eq("t3_repress", bus.throw_pulse, 1);
        check_eq("t3_count2", bus.pepper_count, 1);
        repeat (12) step();

        // 4: exhaust supply, then refill and saturate
        do_reset();
        pulses = 0;
        for (int p = 0; p < 4; p++) begin
            press_once();
            if (p == 3) check_eq("t4_no_throw", bus.throw_pulse, 0);
            pulses += int'(bus.throw_pulse);
            repeat (12) step();
        end
        check_eq("t4_pulses", pulses, 3);
        check_eq("t4_empty", bus.pepper_count, 0);
        check_eq("t4_have", bus.have_pepper, 0);
        check_eq("t4_spray_idle", bus.spray_active, 0);
        bus.refill = 1'b1;
        step();
        bus.refill = 1'b0;
        check_eq("t4_refill1", bus.pepper_count, 1);
        for (int r = 0; r < 6; r++) begin
            bus.refill = 1'b1;
            step();
            bus.refill = 1'b0;
            step();
        end
        check_eq("t4_sat", bus.pepper_count, 5);

        // 5: left-facing clamp at x=0; throw+refill together at full supply
        do_reset();
        bus.ChefX = 10'd10;
        bus.chef_left = 1'b1;
        set_enemy(0, 0, 200);
        set_enemy(1, 1000, 200);
        press_once();
        repeat (3) step();
        check_eq("t5_left_hit", bus.enemy_stunned, 4'b0001);
        repeat (10) step();
        for (int r = 0; r < 3; r++) begin
            bus.refill = 1'b1;
            step();
        end
        bus.refill = 1'b0;
        check_eq("t5_full", bus.pepper_count, 5);
        bus.keycode = 8'd19;
        bus.refill  = 1'b1;
        step();
        bus.keycode = 8'd0;
        bus.refill  = 1'b0;
        check_eq("t5_both_pulse", bus.throw_pulse, 1);
        check_eq("t5_both_count", bus.pepper_count, 5);
        repeat (12) step();

        // 6: re-hit reload, then death clears stun
        do_reset();
        setup_right_scene();
        set_enemy(0, 110, 200);
        press_once();
        found = 0;
        for (int i = 0; i < 700; i++) begin
            step();
            if (m_stun[0] == 100) begin
                found = 1;
                break;
            end
        end
        check_eq("t6_reach100", found, 1);
        press_once();
        n = 0;
        for (int i = 0; i < 550; i++) begin
            step();
            n += int'(bus.enemy_stunned[0]);
        end
        check_eq("t6_reload", n, 550);
        bus.enemy_alive = 4'b1110;
        step();
        check_eq("t6_dead", bus.enemy_stunned[0], 0);
        bus.enemy_alive = 4'b1111;
        repeat (5) step();

        // 7: reset in the middle of a spray
        do_reset();
        setup_right_scene();
        press_once();
        repeat (3) step();
        check_eq("t7_spraying", bus.spray_active, 1);
        do_reset();
        step();
        check_eq("t7_after", bus.spray_active, 0);

        // random traffic around the chef
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) bus.keycode = ($urandom_range(0, 1) == 0) ? 8'd19 : 8'd0;
            bus.refill = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 30) == 0) bus.chef_left = ~bus.chef_left;
            for (int k = 0; k < 4; k++) begin
                set_enemy(k, 70 + int'($urandom_range(0, 60)), 194 + int'($urandom_range(0, 12)));
                bus.enemy_alive[k] = ($urandom_range(0, 15) != 0);
            end
            step();
        end

        check_eq("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
